// File: rtl/irq_arbiter_8_pkg.sv
// Shared constants, FSM state type and vector-address helper for the
// 8-source interrupt arbiter.
package irq_pkg;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_1000;
    localparam logic [31:0] DEF_VECTOR_STRIDE = 32'h0000_0010;

    // OFFER means an interrupt is being presented to the redirect logic.
    // The in-service phase lives in the In_Service bitmap, not in the FSM.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Handler address for a source index; wraps silently at 32 bits.
    function automatic logic [31:0] vector_addr(
        input logic [31:0]     base,
        input logic [31:0]     stride,
        input logic [ID_W-1:0] id
    );
        return base + ({{(32-ID_W){1'b0}}, id} * stride);
    endfunction

endpackage

// File: rtl/irq_arbiter_8_if.sv
// Handshake/bus bundle between the interrupt arbiter and the CPU side.
interface irq_arbiter_8_if;
    import irq_pkg::*;

    logic [NUM_SRC-1:0] irq_req;
    logic [NUM_SRC-1:0] irq_mask;
    logic               int_enable;
    logic               irq_ack;
    logic               eret;
    logic               irq_valid;
    logic [ID_W-1:0]    irq_id;
    logic [31:0]        irq_vector;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic               no_pending;

    // CPU / device side: drives requests and the handshake.
    modport master (
        output irq_req, irq_mask, int_enable, irq_ack, eret,
        input  irq_valid, irq_id, irq_vector, pending, in_service, no_pending
    );

    // Arbiter side.
    modport slave (
        input  irq_req, irq_mask, int_enable, irq_ack, eret,
        output irq_valid, irq_id, irq_vector, pending, in_service, no_pending
    );

endinterface

// File: rtl/irq_arbiter_8_prio_enc.sv
// 8-bit highest-set-bit encoder: found = any bit set, idx = highest set index.
module irq_prio_enc_8
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Fixed priority, bit 7 highest.
    always_comb begin
        found = |vec;
        casez (vec)
            8'b1???_????: idx = 3'd7;
            8'b01??_????: idx = 3'd6;
            8'b001?_????: idx = 3'd5;
            8'b0001_????: idx = 3'd4;
            8'b0000_1???: idx = 3'd3;
            8'b0000_01??: idx = 3'd2;
            8'b0000_001?: idx = 3'd1;
            8'b0000_0001: idx = 3'd0;
            default:      idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/irq_arbiter_8.sv
// 8-source interrupt arbiter/sequencer: latches requests, picks the highest
// eligible source, offers it with a valid/ack handshake and tracks nesting.
module irq_arbiter_8
    import irq_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] EDGE_MASK     = 8'hFF,
    parameter logic [31:0]        VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [31:0]        VECTOR_STRIDE = DEF_VECTOR_STRIDE
)
(
    input  logic          clk,
    input  logic          rst_n,
    irq_arbiter_8_if.slave bus
);

    arb_state_t         state_r;
    logic               valid_r;
    logic [ID_W-1:0]    id_r;
    logic [NUM_SRC-1:0] hist_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] in_service_r;
    logic               no_pending_r;

    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] cand_s;
    logic               win_found_s;
    logic [ID_W-1:0]    win_idx_s;
    logic               is_found_s;
    logic [ID_W-1:0]    is_idx_s;
    logic               eligible_s;
    logic               ack_take_s;
    logic               withdraw_s;
    logic [NUM_SRC-1:0] ack_onehot_s;
    logic [NUM_SRC-1:0] eret_onehot_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [NUM_SRC-1:0] in_service_nxt_s;

    assign cand_s = pending_r & bus.irq_mask;

    irq_prio_enc_8 u_win_enc (
        .vec   (cand_s),
        .found (win_found_s),
        .idx   (win_idx_s)
    );

    irq_prio_enc_8 u_is_enc (
        .vec   (in_service_r),
        .found (is_found_s),
        .idx   (is_idx_s)
    );

    // Request capture, arbitration qualifiers and next-state of the bitmaps.
    // Ack clears first and new set requests are OR'd in after, so a fresh
    // edge/level on the acked source keeps it pending.
    always_comb begin
        set_s         = (EDGE_MASK & bus.irq_req & ~hist_r) | (~EDGE_MASK & bus.irq_req);
        eligible_s    = bus.int_enable & win_found_s & (~is_found_s | (win_idx_s > is_idx_s));
        ack_take_s    = (state_r == OFFER) & bus.irq_ack;
        withdraw_s    = (state_r == OFFER) & ~bus.irq_ack &
                        (~bus.int_enable | ~bus.irq_mask[id_r]);
        if (ack_take_s) begin
            ack_onehot_s = 8'd1 << id_r;
        end else begin
            ack_onehot_s = 8'd0;
        end
        if (bus.eret && is_found_s) begin
            eret_onehot_s = 8'd1 << is_idx_s;
        end else begin
            eret_onehot_s = 8'd0;
        end
        pending_nxt_s    = (pending_r & ~ack_onehot_s) | set_s;
        in_service_nxt_s = (in_service_r & ~eret_onehot_s) | ack_onehot_s;
    end

    // Offer/handshake FSM with registered valid and id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            id_r    <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (eligible_s) begin
                        state_r <= OFFER;
                        valid_r <= 1'b1;
                        id_r    <= win_idx_s;
                    end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                OFFER: begin
                    if (ack_take_s || withdraw_s) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= OFFER;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Pending/in-service bitmaps, edge history and the registered idle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r       <= 8'd0;
            pending_r    <= 8'd0;
            in_service_r <= 8'd0;
            no_pending_r <= 1'b1;
        end else begin
            hist_r       <= bus.irq_req;
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
            no_pending_r <= ~|(pending_nxt_s & bus.irq_mask);
        end
    end

    assign bus.irq_valid  = valid_r;
    assign bus.irq_id     = id_r;
    assign bus.irq_vector = vector_addr(VECTOR_BASE, VECTOR_STRIDE, id_r);
    assign bus.pending    = pending_r;
    assign bus.in_service = in_service_r;
    assign bus.no_pending = no_pending_r;

endmodule
